// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pipe
//  Purpose  : Handshaked instruction-decode stage. Splits the instruction into
//             fields, reads two sources with writeback bypass, tracks pending
//             destination writes in a scoreboard to stall RAW/WAW hazards,
//             and holds the decoded result in a one-entry output register.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter int          XLEN         = 32,
    parameter int          RADDR_W      = 5,
    parameter int          ADDR_W       = 26,
    parameter logic [63:0] NOWRITE_MASK = 64'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [5:0]         out_funct,
    output logic [RADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]    out_rs_val,
    output logic [XLEN-1:0]    out_rt_val,
    output logic [XLEN-1:0]    out_imm,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_wen
);

    localparam int NREG = 2 ** RADDR_W;

    // Output register and scoreboard state
    logic               out_valid_q;
    logic [5:0]         opcode_q;
    logic [5:0]         funct_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    rs_val_q;
    logic [XLEN-1:0]    rt_val_q;
    logic [XLEN-1:0]    imm_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               wen_q;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;

    // Field extraction from the offered instruction
    logic [5:0]         w_opcode;
    logic [RADDR_W-1:0] w_rd;
    logic [RADDR_W-1:0] w_rs;
    logic [RADDR_W-1:0] w_rt;
    logic               w_wen;

    assign w_opcode  = in_instr[31:26];
    assign w_rd      = in_instr[21 +: RADDR_W];
    assign w_rs      = in_instr[16 +: RADDR_W];
    assign w_rt      = in_instr[11 +: RADDR_W];
    assign w_wen     = ~NOWRITE_MASK[w_opcode] & (w_rd != '0);
    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;

    // Hazard detection: a held producer blocks its readers until it has
    // been handed off and written back; writeback in this cycle releases.
    logic w_hold_rs, w_hold_rt, w_wb_rs, w_wb_rt, w_wb_rd;
    logic w_rs_ok, w_rt_ok, w_dst_stall, w_hazard;
    logic w_accept, w_handoff;

    assign w_hold_rs   = out_valid_q & wen_q & (rd_q == w_rs);
    assign w_hold_rt   = out_valid_q & wen_q & (rd_q == w_rt);
    assign w_wb_rs     = wb_valid & (wb_addr == w_rs);
    assign w_wb_rt     = wb_valid & (wb_addr == w_rt);
    assign w_wb_rd     = wb_valid & (wb_addr == w_rd);
    assign w_rs_ok     = (w_rs == '0) | (~w_hold_rs & (~busy_q[w_rs] | w_wb_rs));
    assign w_rt_ok     = (w_rt == '0) | (~w_hold_rt & (~busy_q[w_rt] | w_wb_rt));
    // Second write to a still-pending destination waits so writebacks stay ordered
    assign w_dst_stall = w_wen & busy_q[w_rd] & ~w_wb_rd;
    assign w_hazard    = ~w_rs_ok | ~w_rt_ok | w_dst_stall;

    assign in_ready  = ~rst & ~flush & ~w_hazard & (~out_valid_q | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_handoff = out_valid_q & out_ready;

    // Operand selection with writeback bypass (r0 never bypassed)
    logic [XLEN-1:0] w_rs_val, w_rt_val;
    assign w_rs_val = (w_wb_rs & (w_rs != '0)) ? wb_data : rf_rdata1;
    assign w_rt_val = (w_wb_rt & (w_rt != '0)) ? wb_data : rf_rdata2;

    // Scoreboard next state: clear on writeback, set on handoff (set wins)
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (w_handoff & wen_q) begin
            busy_d[rd_q] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output register: load on accept, drop on handoff or flush, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
            rd_q        <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
        end else begin
            out_valid_q <= w_accept | (out_valid_q & ~out_ready & ~flush);
            if (w_accept) begin
                opcode_q <= w_opcode;
                funct_q  <= in_instr[5:0];
                rd_q     <= w_rd;
                rs_val_q <= w_rs_val;
                rt_val_q <= w_rt_val;
                imm_q    <= {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
                addr_q   <= in_instr[ADDR_W-1:0];
                wen_q    <= w_wen;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opcode = opcode_q;
    assign out_funct  = funct_q;
    assign out_rd     = rd_q;
    assign out_rs_val = rs_val_q;
    assign out_rt_val = rt_val_q;
    assign out_imm    = imm_q;
    assign out_addr   = addr_q;
    assign out_wen    = wen_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_pipe
//  Purpose  : Self-checking bench for decode_pipe: directed vectors, a
//             behavioural reference compared every cycle, and literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    localparam logic [63:0] C_MASK = 64'h8000_0000_0000_0010;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, wb_valid, out_valid, out_ready, out_wen;
    logic [31:0] in_instr, rf_rdata1, rf_rdata2, wb_data, out_rs_val, out_rt_val, out_imm;
    logic [4:0]  rf_raddr1, rf_raddr2, wb_addr, out_rd;
    logic [5:0]  out_opcode, out_funct;
    logic [25:0] out_addr;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .RADDR_W(5), .ADDR_W(26), .NOWRITE_MASK(C_MASK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_rd(out_rd),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
        .out_addr(out_addr), .out_wen(out_wen)
    );

    // Register file contents: register i reads as 0xA0000000 | i
    logic [31:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    int n_cmp = 0;
    int n_err = 0;
    int hq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [10:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    // ---------------- behavioural reference ----------------
    bit          started = 0;
    bit          m_valid = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rs_val = '0, m_rt_val = '0;
    bit          m_wen = 0;
    bit   [31:0] m_busy = '0;

    function automatic bit writes(input logic [31:0] ins);
        return !C_MASK[ins[31:26]] && (ins[25:21] != 0);
    endfunction

    function automatic bit wb_to(input logic [4:0] r);
        return wb_valid && (wb_addr == r);
    endfunction

    // A source is usable unless its producer is still held, or it is
    // pending and not being written back right now.
    function automatic bit src_ok(input logic [4:0] s);
        if (s == 0) return 1;
        if (m_valid && m_wen && m_instr[25:21] == s) return 0;
        if (!m_busy[s]) return 1;
        return wb_to(s);
    endfunction

    function automatic bit f_ready();
        logic [4:0] d;
        d = in_instr[25:21];
        if (rst || flush) return 0;
        if (m_valid && !out_ready) return 0;
        if (!src_ok(in_instr[20:16]) || !src_ok(in_instr[15:11])) return 0;
        if (writes(in_instr) && m_busy[d] && !wb_to(d)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] s);
        return (wb_to(s) && s != 0) ? wb_data : rf_mem[s];
    endfunction

    function automatic bit [31:0] f_busy_next();
        bit [31:0] b;
        b = m_busy;
        if (wb_valid) b[wb_addr] = 1'b0;
        if (m_valid && out_ready && m_wen) b[m_instr[25:21]] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk) begin
        started <= 1;
        if (rst) begin
            m_valid <= 0; m_instr <= '0; m_rs_val <= '0; m_rt_val <= '0;
            m_wen <= 0; m_busy <= '0;
        end else begin
            m_busy <= f_busy_next();
            if (in_valid && f_ready()) begin
                m_valid  <= 1;
                m_instr  <= in_instr;
                m_rs_val <= opnd(in_instr[20:16]);
                m_rt_val <= opnd(in_instr[15:11]);
                m_wen    <= writes(in_instr);
            end else if ((m_valid && out_ready) || flush) begin
                m_valid <= 0;
            end
        end
    end

    // Per-cycle comparison against the reference, plus handoff log
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, f_ready());
            chk("rf_raddr1", rf_raddr1, in_instr[20:16]);
            chk("rf_raddr2", rf_raddr2, in_instr[15:11]);
            chk("out_valid", out_valid, m_valid);
            chk("out_opcode", out_opcode, m_instr[31:26]);
            chk("out_funct", out_funct, m_instr[5:0]);
            chk("out_rd", out_rd, m_instr[25:21]);
            chk("out_rs_val", out_rs_val, m_rs_val);
            chk("out_rt_val", out_rt_val, m_rt_val);
            chk("out_imm", out_imm, {{16{m_instr[15]}}, m_instr[15:0]});
            chk("out_addr", out_addr, m_instr[25:0]);
            chk("out_wen", out_wen, m_wen);
            if (out_valid && out_ready) hq.push_back(int'(out_rd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
        rst = 1; in_valid = 0; in_instr = '0; flush = 0;
        wb_valid = 0; wb_addr = '0; wb_data = '0; out_ready = 0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rd", out_rd, 0);
        rst = 0;

        // Field decode
        in_instr = 32'h2C43FFFC; in_valid = 1; out_ready = 1; #1;
        chk("fd_raddr1", rf_raddr1, 3);
        chk("fd_raddr2", rf_raddr2, 31);
        chk("fd_in_ready", in_ready, 1);
        step(); in_valid = 0; #1;
        chk("fd_valid", out_valid, 1);
        chk("fd_opcode", out_opcode, 6'h0B);
        chk("fd_rd", out_rd, 2);
        chk("fd_imm", out_imm, 32'hFFFF_FFFC);
        chk("fd_funct", out_funct, 6'h3C);
        chk("fd_rs_val", out_rs_val, 32'hA000_0003);
        chk("fd_rt_val", out_rt_val, 32'hA000_001F);
        chk("fd_wen", out_wen, 1);

        // RAW stall and bypass on r5
        step();
        in_instr = mk(6'd1, 5'd5, 5'd0, 5'd0, 11'd0); in_valid = 1;
        step();
        in_instr = mk(6'd1, 5'd6, 5'd5, 5'd0, 11'd0); #1;
        chk("raw_held_rd", out_rd, 5);
        chk("raw_held_stall", in_ready, 0);
        step(); chk("raw_stall1", in_ready, 0);
        step(); chk("raw_stall2", in_ready, 0);
        step();
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; #1;
        chk("raw_release", in_ready, 1);
        step(); wb_valid = 0; in_valid = 0; #1;
        chk("raw_bypass", out_rs_val, 32'hDEAD_BEEF);
        chk("raw_rd", out_rd, 6);

        // Backpressure with three independent instructions
        step(); hq.delete();
        out_ready = 0; in_instr = mk(6'd2, 5'd8, 5'd0, 5'd0, 11'd1); in_valid = 1;
        step();
        in_instr = mk(6'd2, 5'd9, 5'd0, 5'd0, 11'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_rd_stable", out_rd, 8);
            chk("bp_imm_stable", out_imm, 1);
            step();
        end
        out_ready = 1; #1;
        chk("bp_release", in_ready, 1);
        step(); in_instr = mk(6'd2, 5'd10, 5'd0, 5'd0, 11'd3);
        step(); in_valid = 0;
        step();
        chk("bp_count", hq.size(), 3);
        chk("bp_order0", (hq.size() > 0) ? hq[0] : -1, 8);
        chk("bp_order1", (hq.size() > 1) ? hq[1] : -1, 9);
        chk("bp_order2", (hq.size() > 2) ? hq[2] : -1, 10);

        // Flush of a held r7 producer
        in_instr = mk(6'd1, 5'd7, 5'd0, 5'd0, 11'd0); in_valid = 1; out_ready = 0;
        step();
        in_valid = 0; flush = 1; #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 0; in_instr = mk(6'd1, 5'd11, 5'd7, 5'd0, 11'd0); in_valid = 1; #1;
        chk("fl_dropped", out_valid, 0);
        chk("fl_reader_ok", in_ready, 1);
        out_ready = 1;
        step(); in_valid = 0; #1;
        chk("fl_reader_valid", out_valid, 1);
        chk("fl_reader_rd", out_rd, 11);

        // Non-writing opcodes and r0 destination
        step();
        in_instr = mk(6'd4, 5'd13, 5'd0, 5'd0, 11'd0); in_valid = 1;
        step();
        in_instr = mk(6'd1, 5'd17, 5'd13, 5'd0, 11'd0); #1;
        chk("nw_wen", out_wen, 0);
        chk("nw_reader_ok", in_ready, 1);
        step();
        in_instr = mk(6'd1, 5'd0, 5'd0, 5'd0, 11'd0);
        step();
        in_instr = mk(6'd63, 5'd16, 5'd0, 5'd0, 11'd0); #1;
        chk("r0_wen", out_wen, 0);
        step();
        in_instr = mk(6'd1, 5'd19, 5'd16, 5'd13, 11'd0); #1;
        chk("op63_wen", out_wen, 0);
        chk("nw_dep_ok", in_ready, 1);
        step();

        // Reset mid-stream discards held instruction and scoreboard
        in_instr = mk(6'd1, 5'd14, 5'd0, 5'd0, 11'd0);
        step();
        in_instr = mk(6'd1, 5'd20, 5'd14, 5'd0, 11'd0);
        step();
        chk("pre_rst_stall", in_ready, 0);
        rst = 1; #1;
        chk("rst1_in_ready", in_ready, 0);
        step(); chk("rst2_in_ready", in_ready, 0);
        step(); rst = 0; #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_ready", in_ready, 1);
        step(); in_valid = 0; #1;
        chk("post_rst_accept", out_valid, 1);
        chk("post_rst_rd", out_rd, 20);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
